// File: rtl/mem_access_sequencer.sv
// Word-select sequencer for an 8-word NAND-latch array: one read or write at a time,
// with programmable setup/pulse/hold phases and a single-cycle completion response.
module mem_access_sequencer #(
  parameter int DATA_W    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              adr0,
  output logic              adr1,
  output logic              adr2,
  output logic              select,
  output logic              wr_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $error("mem_access_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          adr_q;
  logic                select_q;
  logic                wr_en_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  // Ready is the only combinational output; it must drop in the same cycle rst is raised.
  assign req_ready = (state_q == IDLE) && !rst;

  assign {adr0, adr1, adr2} = adr_q;
  assign select    = select_q;
  assign wr_en     = wr_en_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // NOTE: every flop here uses <= so all branches see the pre-edge values of state and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      select_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            state_q <= SETUP;
            cnt_q   <= CNT_W'(SETUP_CYC - 1);
            adr_q   <= req_addr;
            wr_en_q <= req_write;
            wdata_q <= req_wdata;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q  <= PULSE;
            select_q <= 1'b1;
            cnt_q    <= CNT_W'(PULSE_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_q  <= HOLD;
            select_q <= 1'b0;
            cnt_q    <= CNT_W'(HOLD_CYC - 1);
            // wr_en_q still carries the latched request type here.
            if (!wr_en_q) rsp_rdata_q <= rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
            wr_en_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: directed accesses against a small array model,
// plus a second instance with stretched setup/hold timing.
module tb_mem_access_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       adr0, adr1, adr2, select, wr_en;
  logic [3:0] wdata, rdata;

  logic       p_req_valid, p_req_ready, p_req_write;
  logic [2:0] p_req_addr;
  logic [3:0] p_req_wdata;
  logic       p_rsp_valid;
  logic [3:0] p_rsp_rdata;
  logic       p_adr0, p_adr1, p_adr2, p_select, p_wr_en;
  logic [3:0] p_wdata;
  logic [3:0] p_rdata = 4'h5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .select(select), .wr_en(wr_en), .wdata(wdata), .rdata(rdata)
  );

  mem_access_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut_p (
    .clk(clk), .rst(rst),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_write(p_req_write),
    .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata),
    .adr0(p_adr0), .adr1(p_adr1), .adr2(p_adr2),
    .select(p_select), .wr_en(p_wr_en), .wdata(p_wdata), .rdata(p_rdata)
  );

  // Array model: combinational read, write on a rising edge while selected with wr_en.
  logic [3:0] mem [8];
  assign rdata = mem[{adr0, adr1, adr2}];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'(i);
      mem[3] <= 4'h6;
      mem[7] <= 4'h9;
    end else if (select && wr_en) begin
      mem[{adr0, adr1, adr2}] <= wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] rdata;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Monitor: pops one expectation per response and checks its timing and data.
  logic [3:0] prev_arr;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no pending access at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        check("rsp_wr_en_low", 32'(wr_en), 32'd0);
      end
    end
    if (select) check("sel_addr_stable", 32'({adr0, adr1, adr2, wr_en}), 32'(prev_arr));
    prev_arr = {adr0, adr1, adr2, wr_en};
  end

  // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic start(input logic w, input logic [2:0] a, input logic [3:0] d);
    int n = 0;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
  endtask

  // Full access with per-cycle array-side checks; returns at the negedge of the rsp cycle.
  task automatic issue(input logic w, input logic [2:0] a, input logic [3:0] d,
                       input logic [3:0] exp_rsp, input logic keep);
    start(w, a, d);
    if (!keep) req_valid = 1'b0;
    sb_q.push_back('{rdata: exp_rsp, cyc: cyc + 4});
    for (int k = 1; k <= 4; k++) begin
      check("adr", 32'({adr0, adr1, adr2}), 32'(a));
      check("wr_en", 32'(wr_en), 32'(w));
      check("wdata", 32'(wdata), 32'(d));
      check("select", 32'(select), 32'(k == 2 || k == 3));
      check("busy_not_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 4'hF;
    p_req_valid = 1'b0; p_req_write = 1'b0; p_req_addr = 3'd0; p_req_wdata = 4'h0;

    // Reset with a request asserted alongside it: must not be accepted.
    repeat (3) @(negedge clk);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    check("rst_select", 32'(select), 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("post_rst_adr", 32'({adr0, adr1, adr2}), 32'd0);
    check("post_rst_wr_en", 32'(wr_en), 32'd0);
    check("post_rst_wdata", 32'(wdata), 32'd0);
    prev_arr = 4'h0;

    issue(1'b1, 3'd5, 4'hA, 4'h0, 1'b0);   // write: rsp_rdata stays at reset value
    issue(1'b0, 3'd3, 4'h0, 4'h6, 1'b0);   // read preloaded word
    issue(1'b1, 3'd2, 4'h3, 4'h6, 1'b0);   // write leaves last read data
    issue(1'b0, 3'd5, 4'h0, 4'hA, 1'b0);   // read back the first write

    // Back-to-back with req_valid held: second accept lands in the first rsp cycle.
    issue(1'b1, 3'd0, 4'hC, 4'hA, 1'b1);
    issue(1'b0, 3'd7, 4'h0, 4'h9, 1'b0);
    issue(1'b0, 3'd0, 4'h0, 4'hC, 1'b0);

    // Reset during the select pulse of a read.
    start(1'b0, 3'd5, 4'h0);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_pulse", 32'(select), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_select", 32'(select), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_ready_in_rst", 32'(req_ready), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_adr", 32'({adr0, adr1, adr2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    issue(1'b0, 3'd3, 4'h0, 4'h6, 1'b0);

    // Stretched timing instance: setup 3, pulse 1, hold 2.
    check("p_ready", 32'(p_req_ready), 32'd1);
    p_req_valid = 1'b1;
    p_req_addr  = 3'd6;
    @(negedge clk);
    p_req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check("p_select", 32'(p_select), 32'(k == 4));
      check("p_rsp_valid", 32'(p_rsp_valid), 32'(k == 7));
      check("p_adr", 32'({p_adr0, p_adr1, p_adr2}), 32'd6);
      if (k == 7) check("p_rsp_rdata", 32'(p_rsp_rdata), 32'h5);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Initiator side of the 8-word bitcell NAND-latch array's word-select interface. Accepts one read or write request at a time over a valid/ready port and drives the array's 3-bit address and word-select strobe with programmable setup, pulse and hold phases. Samples read data at the end of the pulse and returns it as a single-cycle response. Sits between the system-side request logic and the array's address decoder, write-enable and data lines.

## Interface
- DATA_W, 4, width of one array word
- SETUP_CYC, 1, cycles address/wr_en/wdata are stable before select rises (>=1)
- PULSE_CYC, 2, cycles select stays high (>=1)
- HOLD_CYC, 1, cycles address/wr_en/wdata stay stable after select falls (>=1)

- clk  in  1  single clock, all flops on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle and able to accept
- req_write  in  1  1 = write, 0 = read
- req_addr  in  3  word index 0..7
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse, reads and writes
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads
- adr0, adr1, adr2  out  1 each  array address; word index = {adr0,adr1,adr2} (adr0 = MSB)
- select  out  1  word-select strobe to the decoder
- wr_en  out  1  array write enable
- wdata  out  DATA_W  array write data
- rdata  in  DATA_W  array read data

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: req_ready = 1 (forced 0 while rst high). On req_valid && req_ready: latch addr, write, wdata; go to SETUP.
- SETUP: adr* = latched addr, wr_en = latched write, wdata = latched wdata, select = 0; SETUP_CYC cycles, then PULSE.
- PULSE: select = 1, all other array-facing outputs unchanged; PULSE_CYC cycles. On the edge leaving PULSE, reads capture rdata into rsp_rdata.
- HOLD: select = 0, adr*/wr_en/wdata unchanged; HOLD_CYC cycles, then IDLE.
- Entering IDLE from HOLD: rsp_valid = 1 for exactly one cycle; wr_en drops to 0; adr* and wdata keep last values (no toggling between accesses).
- rsp_rdata updates only on reads; writes leave it unchanged.
- req_* ignored outside IDLE; no queueing, no request dropped when handshake rules are followed.
- Phase counter: single down-counter sized to clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1); parameters <1 rejected at elaboration.
- All array-facing outputs (adr*, select, wr_en, wdata) driven directly from flops, glitch-free.

## Timing
- Reset values: req_ready 0 (during rst), rsp_valid 0, rsp_rdata 0, adr0/1/2 0, select 0, wr_en 0, wdata 0; state IDLE. req_ready = 1 in the first cycle after rst deasserts.
- Accept on edge E0. Cycles 1..S: SETUP; S+1..S+P: PULSE; S+P+1..S+P+H: HOLD; cycle S+P+H+1: IDLE with rsp_valid = 1 and req_ready = 1. Defaults: select high cycles 2-3, rsp_valid cycle 5.
- Back-to-back: a request accepted in the rsp_valid cycle starts SETUP next cycle; throughput one access per S+P+H+1 cycles.
- select never high while adr* or wr_en changes; adr*/wr_en change only on IDLE→SETUP edge (wr_en also on HOLD→IDLE).
- rst mid-operation: next edge forces IDLE and reset values; select falls immediately, no rsp_valid for the aborted access, a write may be partially applied.
- rst and req_valid simultaneously: request not accepted.

## Test plan
- Reset then idle: rst high 3 cycles, release -> req_ready 1 in first post-reset cycle, all other outputs 0.
- Write addr 5, wdata 0xA (defaults) -> cycles 1-4: adr0/1/2 = 1/0/1, wr_en 1, wdata 0xA; select 1 cycles 2-3 only; cycle 5 rsp_valid 1, wr_en 0.
- Read addr 3 with array model returning 0x6 -> adr 0/1/1, wr_en 0, select cycles 2-3, rsp_valid cycle 5 with rsp_rdata 0x6; following write leaves rsp_rdata 0x6.
- Back-to-back: req_valid held high for write addr 0 then read addr 7 -> second accept in first rsp_valid cycle, second rsp_valid exactly 5 cycles later; select never high across the address change.
- Parameters SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 -> select high only cycle 4, rsp_valid cycle 7.
- rst asserted during PULSE of a read -> select 0 next cycle, no rsp_valid, rsp_rdata 0, req_ready 1 after release.
